// File: rtl/sprite_line_fetcher.sv
// Sprite line fetcher: reads one 16-pixel row of a 16x16 sprite ROM during horizontal blank
// and displays it through a double buffer. Define SPRITE_FLIP_H_EN to honour flip_h_i.
module sprite_line_fetcher #(
    parameter int COORD_W = 10
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               line_start_i,
    input  logic [COORD_W-1:0] next_line_i,
    input  logic [COORD_W-1:0] sprite_x_i,
    input  logic [COORD_W-1:0] sprite_y_i,
    input  logic               flip_h_i,
    output logic [3:0]         rom_x_o,
    output logic [3:0]         rom_y_o,
    input  logic [1:0]         rom_pal_i,
    input  logic [COORD_W-1:0] pixel_x_i,
    output logic [1:0]         pal_out_o,
    output logic               pal_opaque_o,
    output logic               busy_o
);

`ifdef SPRITE_FLIP_H_EN
    localparam logic FLIP_EN = 1'b1;
`else
    localparam logic FLIP_EN = 1'b0;
`endif

    localparam logic [COORD_W:0] SPAN = (COORD_W+1)'(15);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    state_e               state_q;
    logic [3:0]           col_q;
    logic [3:0]           row_q;
    logic [15:0][1:0]     fetch_buf_q;
    logic [15:0][1:0]     disp_buf_q;
    logic [COORD_W-1:0]   disp_x_q;
    logic [COORD_W-1:0]   pos_x_q;
    logic                 flip_q;
    logic                 busy_q;
    logic [1:0]           pal_q;
    logic                 opaque_q;

    logic [COORD_W:0]     line_ext_s;
    logic [COORD_W:0]     y_ext_s;
    logic                 hit_s;
    logic [3:0]           row_s;
    logic [3:0]           wr_idx_s;
    logic [COORD_W:0]     px_ext_s;
    logic [COORD_W:0]     dx_ext_s;
    logic                 in_rng_s;
    logic [3:0]           disp_idx_s;
    logic [1:0]           disp_pal_s;

    // One extra bit keeps sprite_y + 15 and disp_x + 15 from wrapping at the screen edge.
    assign line_ext_s = {1'b0, next_line_i};
    assign y_ext_s    = {1'b0, sprite_y_i};
    assign hit_s      = (line_ext_s >= y_ext_s) && (line_ext_s <= (y_ext_s + SPAN));
    assign row_s      = next_line_i[3:0] - sprite_y_i[3:0];
    assign wr_idx_s   = (FLIP_EN && flip_q) ? (4'd15 - col_q) : col_q;

    assign px_ext_s   = {1'b0, pixel_x_i};
    assign dx_ext_s   = {1'b0, disp_x_q};
    assign in_rng_s   = (px_ext_s >= dx_ext_s) && (px_ext_s <= (dx_ext_s + SPAN));
    assign disp_idx_s = pixel_x_i[3:0] - disp_x_q[3:0];
    assign disp_pal_s = disp_buf_q[disp_idx_s];

    // Fetch FSM: line_start always wins, aborting any fetch or commit in progress.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            col_q       <= 4'd0;
            row_q       <= 4'd0;
            fetch_buf_q <= '0;
            disp_buf_q  <= '0;
            disp_x_q    <= '0;
            pos_x_q     <= '0;
            flip_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else if (line_start_i) begin
            pos_x_q <= sprite_x_i;
            flip_q  <= flip_h_i;
            col_q   <= 4'd0;
            if (hit_s) begin
                state_q <= ST_FETCH;
                row_q   <= row_s;
                busy_q  <= 1'b1;
            end else begin
                state_q     <= ST_COMMIT;
                row_q       <= 4'd0;
                busy_q      <= 1'b0;
                fetch_buf_q <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_IDLE;
                end
                ST_FETCH: begin
                    fetch_buf_q[wr_idx_s] <= rom_pal_i;
                    col_q                 <= col_q + 4'd1;
                    if (col_q == 4'd15) begin
                        state_q <= ST_COMMIT;
                        row_q   <= 4'd0;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_COMMIT: begin
                    disp_buf_q <= fetch_buf_q;
                    disp_x_q   <= pos_x_q;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    col_q   <= 4'd0;
                    row_q   <= 4'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Display path: one-cycle registered lookup into the committed buffer.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pal_q    <= 2'b00;
            opaque_q <= 1'b0;
        end else if (in_rng_s) begin
            pal_q    <= disp_pal_s;
            opaque_q <= (disp_pal_s != 2'b00);
        end else begin
            pal_q    <= 2'b00;
            opaque_q <= 1'b0;
        end
    end

    // col and row are held at zero outside FETCH, so they drive the ROM address directly.
    assign rom_x_o      = col_q;
    assign rom_y_o      = row_q;
    assign busy_o       = busy_q;
    assign pal_out_o    = pal_q;
    assign pal_opaque_o = opaque_q;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Self-checking bench for sprite_line_fetcher: random ROM, behavioural display-buffer model.
module tb_sprite_line_fetcher;

    localparam int CW = 10;

    logic          clk;
    logic          reset_n;
    logic          line_start;
    logic [CW-1:0] next_line;
    logic [CW-1:0] sprite_x;
    logic [CW-1:0] sprite_y;
    logic          flip_h;
    logic [3:0]    rom_x;
    logic [3:0]    rom_y;
    logic [1:0]    rom_pal;
    logic [CW-1:0] pixel_x;
    logic [1:0]    pal_out;
    logic          pal_opaque;
    logic          busy;

    logic [1:0] rom_mem [256];
    logic [1:0] m_disp [16];
    int         m_dx;
    int         n_checks;
    int         n_pass;

    sprite_line_fetcher #(.COORD_W(CW)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .line_start_i(line_start),
        .next_line_i(next_line), .sprite_x_i(sprite_x), .sprite_y_i(sprite_y),
        .flip_h_i(flip_h), .rom_x_o(rom_x), .rom_y_o(rom_y), .rom_pal_i(rom_pal),
        .pixel_x_i(pixel_x), .pal_out_o(pal_out), .pal_opaque_o(pal_opaque), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rom_pal = rom_mem[{rom_y, rom_x}];

    function automatic logic [1:0] m_pix(input int p);
        if (p >= m_dx && p <= m_dx + 15) return m_disp[p - m_dx];
        return 2'b00;
    endfunction

    function automatic int clip(input int v);
        if (v < 0) return 0;
        if (v > 1023) return 1023;
        return v;
    endfunction

    task automatic check_pal(input string name, input int p);
        logic [1:0] e;
        e = m_pix(p);
        n_checks++;
        if (pal_out !== e || pal_opaque !== (e != 2'b00))
            $display("FAIL %s px=%0d got pal=%0d opq=%0d exp pal=%0d", name, p, pal_out, pal_opaque, e);
        else n_pass++;
    endtask

    task automatic sweep(input int lo, input int hi);
        @(negedge clk);
        pixel_x = CW'(lo);
        for (int p = lo; p <= hi; p++) begin
            @(negedge clk);
            check_pal("sweep", p);
            pixel_x = CW'(p + 1);
        end
    endtask

    // Issue a line_start, follow the fetch cycle by cycle, then update the model at commit.
    task automatic run_line(input int sx, input int sy, input int nl, input bit fl, input int pix);
        bit hit;
        bit fe;
        int row;
        int cycles;
        logic [3:0] ecol;
        hit = (nl >= sy) && (nl <= sy + 15);
        row = (nl - sy) & 15;
`ifdef SPRITE_FLIP_H_EN
        fe = fl;
`else
        fe = 1'b0;
`endif
        @(negedge clk);
        sprite_x = CW'(sx); sprite_y = CW'(sy); next_line = CW'(nl);
        flip_h = fl; pixel_x = CW'(pix); line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            ecol = 4'(cycles);
            n_checks++;
            if (rom_x !== ecol || rom_y !== 4'(row))
                $display("FAIL rom_addr cyc=%0d got x=%0d y=%0d exp x=%0d y=%0d", cycles, rom_x, rom_y, ecol, row);
            else n_pass++;
            check_pal("dbl_buf", pix);
            cycles++;
            @(negedge clk);
        end
        n_checks++;
        if (cycles != (hit ? 16 : 0))
            $display("FAIL busy_len got=%0d exp=%0d", cycles, hit ? 16 : 0);
        else n_pass++;
        n_checks++;
        if (rom_x !== 4'd0 || rom_y !== 4'd0)
            $display("FAIL rom_idle got x=%0d y=%0d exp 0 0", rom_x, rom_y);
        else n_pass++;
        @(negedge clk);
        check_pal("pre_commit", pix);
        for (int i = 0; i < 16; i++)
            m_disp[i] = hit ? rom_mem[row * 16 + (fe ? 15 - i : i)] : 2'b00;
        m_dx = sx;
        @(negedge clk);
        check_pal("post_commit", pix);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; line_start = 1'b0; next_line = '0; sprite_x = '0;
        sprite_y = '0; flip_h = 1'b0; pixel_x = '0;
        for (int i = 0; i < 256; i++) rom_mem[i] = 2'($urandom_range(0, 3));
        for (int i = 0; i < 16; i++) m_disp[i] = 2'b00;
        m_dx = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || rom_x !== 4'd0 || rom_y !== 4'd0 || pal_out !== 2'b00 || pal_opaque !== 1'b0)
            $display("FAIL reset got busy=%0d rx=%0d ry=%0d pal=%0d opq=%0d exp all 0",
                     busy, rom_x, rom_y, pal_out, pal_opaque);
        else n_pass++;
        reset_n = 1'b1;
        sweep(0, 18);
    endtask

    task automatic test_basic_fetch;
        run_line(200, 100, 100, 1'b0, 5);
        sweep(195, 220);
    endtask

    task automatic test_miss;
        run_line(300, 100, 99, 1'b0, 205);
        sweep(295, 320);
        run_line(200, 100, 116, 1'b0, 305);
        sweep(195, 220);
    endtask

    task automatic test_edge;
        run_line(1015, 1020, 1023, 1'b0, 210);
        sweep(1008, 1023);
    endtask

    task automatic test_flip;
        run_line(40, 93, 100, 1'b1, 1020);
        sweep(38, 58);
    endtask

    task automatic test_abort;
        int pix;
        pix = m_dx + 3;
        @(negedge clk);
        sprite_x = CW'(500); sprite_y = CW'(300); next_line = CW'(305);
        flip_h = 1'b0; pixel_x = CW'(pix); line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            n_checks++;
            if (busy !== 1'b1 || rom_x !== 4'(k))
                $display("FAIL abort_pre k=%0d got busy=%0d x=%0d exp busy=1 x=%0d", k, busy, rom_x, k);
            else n_pass++;
            check_pal("abort_hold", pix);
            @(negedge clk);
        end
        run_line(600, 290, 301, 1'b0, pix);
        sweep(495, 520);
        sweep(595, 620);
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        sprite_x = CW'(100); sprite_y = CW'(50); next_line = CW'(60);
        pixel_x = CW'(m_dx); line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || rom_x !== 4'd0 || rom_y !== 4'd0 || pal_out !== 2'b00 || pal_opaque !== 1'b0)
            $display("FAIL async_rst got busy=%0d rx=%0d ry=%0d pal=%0d opq=%0d exp all 0",
                     busy, rom_x, rom_y, pal_out, pal_opaque);
        else n_pass++;
        @(negedge clk);
        line_start = 1'b1;
        repeat (2) @(negedge clk);
        line_start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL rst_ignore got busy=%0d exp 0", busy);
        else n_pass++;
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) m_disp[i] = 2'b00;
        m_dx = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL post_rst_busy got=%0d exp 0", busy);
        else n_pass++;
        sweep(0, 20);
        sweep(95, 120);
        run_line(100, 50, 60, 1'b0, 3);
        sweep(98, 118);
    endtask

    task automatic test_random;
        int sy, nl, sx, pix;
        for (int it = 0; it < 15; it++) begin
            sy  = $urandom_range(0, 1023);
            nl  = clip(sy + $urandom_range(0, 20) - 2);
            sx  = $urandom_range(0, 1008);
            pix = clip(m_dx + $urandom_range(0, 15));
            run_line(sx, sy, nl, 1'($urandom_range(0, 1)), pix);
            sweep(clip(sx - 3), clip(sx + 18));
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_basic_fetch();
        test_miss();
        test_edge();
        test_flip();
        test_abort();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sprite_line_fetcher.md
SPRITE_LINE_FETCHER -- requirements
Module: sprite_line_fetcher

Interface
REQ-001 Parameter COORD_W, default 10, SHALL set the width of all screen coordinate ports.
REQ-002 Clk  input  1  SHALL be the single clock; every register is rising-edge triggered.
REQ-003 Reset_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 line_start  input  1  SHALL be a one-cycle pulse at horizontal blank requesting a fetch for next_line.
REQ-005 next_line  input  COORD_W  SHALL be the screen row to be displayed after the current row.
REQ-006 sprite_x, sprite_y  input  COORD_W each  SHALL give the sprite's top-left screen position and are sampled on line_start.
REQ-007 flip_h  input  1  SHALL request horizontal mirroring and is sampled on line_start.
REQ-008 rom_x, rom_y  output  4 each  SHALL address the combinational 16x16 sprite ROM.
REQ-009 rom_pal  input  2  SHALL be the ROM palette index, valid in the same cycle as rom_x/rom_y (00 = transparent, 01 red, 10 dark brown, 11 light brown).
REQ-010 pixel_x  input  COORD_W  SHALL be the beam column currently being drawn.
REQ-011 pal_out  output  2  SHALL be the sprite palette index for pixel_x, registered.
REQ-012 pal_opaque  output  1  SHALL be high when pal_out is not 00.
REQ-013 busy  output  1  SHALL be high while in the FETCH state.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH and COMMIT.
REQ-015 On line_start in any state, the block SHALL latch sprite_x, sprite_y and flip_h, and SHALL compute hit = (next_line >= sprite_y) and (next_line <= sprite_y + 15), using COORD_W+1-bit arithmetic so the sum cannot wrap.
REQ-016 If hit, the block SHALL enter FETCH with row = (next_line - sprite_y)[3:0] and col = 0; otherwise it SHALL enter COMMIT with the fetch buffer cleared to all 00.
REQ-017 In FETCH the block SHALL drive rom_y = row and rom_x = col, and SHALL write rom_pal into fetch_buf[col], or into fetch_buf[15-col] when flip is latched; col SHALL increment every cycle.
REQ-018 After the col = 15 write, FETCH SHALL go to COMMIT, so a fetch takes exactly 16 cycles.
REQ-019 COMMIT SHALL copy fetch_buf into disp_buf in one cycle, copy the latched sprite_x into disp_x, then go to IDLE.
REQ-020 A line_start arriving during FETCH or COMMIT SHALL abort the current fetch and restart per REQ-015; disp_buf SHALL NOT be updated from the aborted fetch.
REQ-021 In IDLE and COMMIT, rom_x and rom_y SHALL be 0.
REQ-022 Display path: every cycle, pal_out SHALL be registered as disp_buf[pixel_x - disp_x] when disp_x <= pixel_x <= disp_x + 15 (COORD_W+1-bit compare), and 00 otherwise; latency is 1 cycle from pixel_x.
REQ-023 The display path SHALL keep using the previous disp_buf and disp_x during FETCH (double buffering).
REQ-024 pal_opaque SHALL be registered in the same cycle as pal_out.

Reset
REQ-025 Reset_n low SHALL immediately force: state IDLE, col 0, row 0, fetch_buf and disp_buf all 00, disp_x 0, latched position 0, flip 0, pal_out 00, pal_opaque 0, busy 0, rom_x 0, rom_y 0.
REQ-026 A reset asserted during FETCH SHALL discard the fetch, and no line_start SHALL be honoured while Reset_n is low.

Configuration
REQ-027 With macro SPRITE_FLIP_H_EN defined, flip_h SHALL behave as in REQ-007 and REQ-017.
REQ-028 Without SPRITE_FLIP_H_EN, the flip_h port SHALL remain present but be ignored, and writes SHALL always go to fetch_buf[col].

Verification
REQ-029 Setup: sprite_y=100, sprite_x=200, next_line=100, line_start pulse. Required: busy high for exactly 16 cycles; rom_y=0; rom_x steps 0..15; disp_buf equals ROM row 0 one cycle after busy falls.
REQ-030 With disp_buf holding row 0 and pixel_x swept 195..220: pal_out is 00 for 195..199 and 216..220; pal_out equals the ROM row 0 entry (pixel_x-200) one cycle after pixel_x for 200..215; pal_opaque tracks pal_out != 00.
REQ-031 next_line=99 or next_line=116 with sprite_y=100: no FETCH (busy stays 0); disp_buf all 00 after COMMIT; pal_out 00 across the whole line.
REQ-032 Edge case sprite_y=1020 (COORD_W=10), next_line=1023: hit with row 3 (no wrap); sprite_x=1015 with pixel_x=1023 gives disp_buf[8].
REQ-033 Flip case, SPRITE_FLIP_H_EN defined, flip_h=1, row 7: disp_buf[15-i] equals ROM row 7 entry i for all i. Without the macro, the same stimulus gives the unflipped row.
REQ-034 Abort and reset cases:
- A second line_start at FETCH cycle 8 restarts col at 0, and disp_buf changes only after the second fetch completes.
- Reset_n low at FETCH cycle 5 zeroes all outputs asynchronously.
